sdram_dl_writer: RTL and testbench
==================================

// Module: sdram_dl_writer
// PURPOSE
//  Byte-stream to SDRAM write adapter between the HPS ROM download port and the SDRAM controller's write-capable channel (ch3).
//  - Coalesces byte writes into 16-bit words with byte enables.
//  - Buffers the words in a small FIFO.
//  - Issues them with the controller's toggle req/ack protocol; sdr_rnw is tied 0 (writes only).
//  - Raises backpressure so the download source can pause while SDRAM is busy.
// PARAMETERS
//  FIFO_DEPTH     4   word FIFO entries; power of 2, >=2
//  FLUSH_TIMEOUT  16  idle clk cycles before a half-filled holding word is pushed; >=1
// PORTS
//  clk        in   1   system clock, same clock as SDRAM controller
//  reset      in   1   synchronous, active-high
//  dl_wr      in   1   one-cycle strobe: dl_addr/dl_data valid
//  dl_addr    in   27  byte address
//  dl_data    in   8   byte data
//  dl_end     in   1   one-cycle strobe: flush holding word now
//  dl_wait    out  1   backpressure; source must not strobe dl_wr while high
//  sdr_addr   out  27  to ch3_addr; bit0 always 0
//  sdr_din    out  16  to ch3_din
//  sdr_be     out  2   to ch3_be; [1]=bits15:8, [0]=bits7:0
//  sdr_rnw    out  1   constant 0
//  sdr_req    out  1   toggle request to ch3_req
//  sdr_ack    in   1   toggle ack from ch3_ack
//  busy       out  1   holding valid | FIFO not empty | request outstanding
//  overflow   out  1   sticky: a byte was dropped
// BEHAVIOUR
//  Reset values:
//  - All of the following go to 0: dl_wait, sdr_addr, sdr_din, sdr_be, busy, overflow, FIFO count, holding-valid, timeout counter. State=IDLE.
//  - sdr_req loads the current sdr_ack value, not a constant, so a reset never creates a phantom request.
//  - Reset mid-transaction discards the holding word and the FIFO contents.
//  Byte lane: dl_addr[0]=0 -> sdr_din[7:0], be[0]. dl_addr[0]=1 -> sdr_din[15:8], be[1].
//  Holding register (hold_addr[26:1], hold_data, hold_be, hold_v), on a dl_wr:
//  - !hold_v: load the byte; hold_v=1.
//  - hold_v, same word address, lane bit clear: merge the byte and push the full word (be=11) to the FIFO the same cycle; hold_v=0.
//  - hold_v, same word address, lane bit already set: overwrite that lane (last write wins); no push.
//  - hold_v, different word address: push the held word with its partial be; the new byte goes into the holding register.
//  Timeout and flush:
//  - Timeout counter resets on every dl_wr and counts while hold_v.
//  - Reaching FLUSH_TIMEOUT, or dl_end, pushes the held word.
//  - dl_end on the same cycle as dl_wr: apply the byte first, then flush.
//  FIFO:
//  - Occupancy count is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo DEPTH.
//  - dl_wait = (count >= FIFO_DEPTH-1), registered, so one push is always still possible.
//  - A push with count==FIFO_DEPTH drops the word and sets overflow.
//  - Push and pop in the same cycle: count unchanged.
//  Issue FSM:
//  - IDLE: FIFO non-empty -> drive sdr_addr/{din,be} from the FIFO head, toggle sdr_req -> WAIT.
//  - WAIT: hold the outputs stable; sdr_ack==sdr_req -> pop the head -> IDLE.
//  - One outstanding request at most. A head word issues at earliest 1 cycle after its push.
//  - Back-to-back gap is at least 1 IDLE cycle.
//  - Ack latency is unbounded; no timeout in WAIT.
//  busy is registered and updates 1 cycle after any contributing change.
// TESTING
//  1 Bytes 0x11@0x100, 0x22@0x101 back-to-back -> one req: addr 0x100, din 0x2211, be 11.
//  2 Byte 0xAA@0x203 then idle 16 cycles -> req: addr 0x202, din[15:8]=0xAA, be 10.
//  3 0x01@0x10 then 0x02@0x20 -> 1st req addr 0x10 be 01; 0x02 is held until dl_end/timeout, then req addr 0x20 be 01.
//  4 Ack held off while 8 full words arrive -> dl_wait rises at count 3; writes stop; all 8 complete in order; overflow stays 0.
//  5 Reset asserted in WAIT with sdr_ack!=sdr_req -> after reset sdr_req==sdr_ack, busy 0, no further toggles.
//  6 Ignore dl_wait and push 5 words with no ack -> overflow=1; only 4 words are ever issued.

Source files
------------

// File: rtl/sdram_dl_writer.sv
// Byte-stream download to SDRAM ch3 write adapter: coalesces bytes into 16-bit
// words with byte enables, buffers them and issues them over the toggle req/ack channel.
//
// state  | meaning
// S_IDLE | no request outstanding; issue FIFO head when non-empty
// S_WAIT | request toggled, outputs held until sdr_ack matches sdr_req
module sdram_dl_writer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_wr,
  input  logic [26:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        dl_end,
  output logic        dl_wait,
  output logic [26:0] sdr_addr,
  output logic [15:0] sdr_din,
  output logic [1:0]  sdr_be,
  output logic        sdr_rnw,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic        busy,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_WAIT = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(FLUSH_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [25:0]   hold_addr, n_hold_addr;
  logic [15:0]   hold_data, n_hold_data;
  logic [1:0]    hold_be, n_hold_be;
  logic          hold_v, n_hold_v;
  logic          flush_pend, n_flush_pend;
  logic [TW-1:0] tmo_cnt;

  logic [25:0] fifo_addr [FIFO_DEPTH];
  logic [15:0] fifo_data [FIFO_DEPTH];
  logic [1:0]  fifo_be   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;

  logic        push, push_ok, pop, issue;
  logic [25:0] push_addr;
  logic [15:0] push_data;
  logic [1:0]  push_be;

  logic        lane, same_word, tmo_hit, flush_now;
  logic [15:0] base_data, m_data;
  logic [1:0]  base_be, m_be;

  assign sdr_rnw   = 1'b0;
  assign lane      = dl_addr[0];
  assign same_word = hold_v && (hold_addr == dl_addr[26:1]);
  assign tmo_hit   = hold_v && !dl_wr && (tmo_cnt == TMO_LAST);
  assign flush_now = dl_end || flush_pend || tmo_hit;

  // Byte merged into the held word when addresses match, else into an empty word
  always_comb begin
    base_data = same_word ? hold_data : 16'h0000;
    base_be   = same_word ? hold_be : 2'b00;
    m_data    = lane ? {dl_data, base_data[7:0]} : {base_data[15:8], dl_data};
    m_be      = base_be | (lane ? 2'b10 : 2'b01);
  end

  always_comb begin
    n_hold_addr  = hold_addr;
    n_hold_data  = hold_data;
    n_hold_be    = hold_be;
    n_hold_v     = hold_v;
    n_flush_pend = 1'b0;
    push         = 1'b0;
    push_addr    = hold_addr;
    push_data    = hold_data;
    push_be      = hold_be;
    if (dl_wr) begin
      n_hold_addr = dl_addr[26:1];
      n_hold_data = m_data;
      n_hold_be   = m_be;
      n_hold_v    = 1'b1;
      if (same_word && !hold_be[lane]) begin
        push      = 1'b1;
        push_data = m_data;
        push_be   = m_be;
        n_hold_v  = 1'b0;
      end else if (hold_v && !same_word) begin
        push = 1'b1;
      end
    end
    // A flush that collides with an eviction push is deferred one cycle
    if (flush_now && n_hold_v) begin
      if (push) begin
        n_flush_pend = 1'b1;
      end else begin
        push      = 1'b1;
        push_addr = n_hold_addr;
        push_data = n_hold_data;
        push_be   = n_hold_be;
        n_hold_v  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_be    <= '0;
      hold_v     <= 1'b0;
      flush_pend <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      hold_addr  <= n_hold_addr;
      hold_data  <= n_hold_data;
      hold_be    <= n_hold_be;
      hold_v     <= n_hold_v;
      flush_pend <= n_flush_pend;
      if (dl_wr)
        tmo_cnt <= TMO_LOAD;
      else if (!hold_v)
        tmo_cnt <= '0;
      else if (tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - TMO_LAST;
    end
  end

  assign push_ok   = push && (count != CNT_FULL);
  assign count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
      fifo_be[wr_ptr]   <= push_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dl_wait  <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      dl_wait <= (count_nxt >= CNT_WAIT);
      if (push && !push_ok) overflow <= 1'b1;
      busy    <= hold_v || (count != '0) || (state == S_WAIT);
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: if (count != '0) begin
        issue     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (sdr_ack == sdr_req) begin
        pop       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // sdr_req reloads from sdr_ack so reset never leaves a request pending
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      sdr_req  <= sdr_ack;
      sdr_addr <= '0;
      sdr_din  <= '0;
      sdr_be   <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        sdr_addr <= {fifo_addr[rd_ptr], 1'b0};
        sdr_din  <= fifo_data[rd_ptr];
        sdr_be   <= fifo_be[rd_ptr];
        sdr_req  <= ~sdr_req;
      end
    end
  end
endmodule

// File: tb/tb_sdram_dl_writer.sv
// Directed bench for sdram_dl_writer with a toggle-ack SDRAM channel model
// that logs every issued request.
module tb_sdram_dl_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_wr = 1'b0;
  logic [26:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_end = 1'b0;
  logic        dl_wait;
  logic [26:0] sdr_addr;
  logic [15:0] sdr_din;
  logic [1:0]  sdr_be;
  logic        sdr_rnw;
  logic        sdr_req;
  logic        sdr_ack = 1'b0;
  logic        busy;
  logic        overflow;

  sdram_dl_writer #(.FIFO_DEPTH(4), .FLUSH_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_end(dl_end), .dl_wait(dl_wait), .sdr_addr(sdr_addr), .sdr_din(sdr_din),
    .sdr_be(sdr_be), .sdr_rnw(sdr_rnw), .sdr_req(sdr_req), .sdr_ack(sdr_ack),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [44:0] rec[$];
  logic        ack_en = 1'b0;
  logic        req_prev = 1'b0;
  int          ack_cnt = 0;
  int          n_tog = 0;

  // Channel model: logs requests, acks after a short delay when enabled
  always @(negedge clk) begin
    if (sdr_req !== req_prev) begin
      n_tog++;
      if (sdr_req !== sdr_ack) rec.push_back({sdr_addr, sdr_din, sdr_be});
    end
    req_prev = sdr_req;
    if (ack_en && sdr_req !== sdr_ack) begin
      if (ack_cnt >= 2) begin
        sdr_ack = sdr_req;
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else
      n_pass++;
  endtask

  task automatic wr(input logic [26:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    @(negedge clk);
    dl_wr = 1'b0;
  endtask

  task automatic pulse_end();
    dl_end = 1'b1;
    @(negedge clk);
    dl_end = 1'b0;
  endtask

  task automatic wait_rec(input int n, input string tag);
    int k = 0;
    while (rec.size() < n && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 64'(rec.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || sdr_req !== sdr_ack) && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic chk_rec(input int i, input string tag, input logic [26:0] a,
                         input logic [15:0] d, input logic [1:0] be);
    logic [44:0] e;
    e = (i < rec.size()) ? rec[i] : '1;
    chk({tag, " addr"}, 64'(e[44:18]), 64'(a));
    chk({tag, " din"},  64'(e[17:2]),  64'(d));
    chk({tag, " be"},   64'(e[1:0]),   64'(be));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [44:0] e;
    int k;
    repeat (3) @(negedge clk);
    chk("rst dl_wait", {63'd0, dl_wait}, 64'd0);
    chk("rst sdr_addr", 64'(sdr_addr), 64'd0);
    chk("rst sdr_din", 64'(sdr_din), 64'd0);
    chk("rst sdr_be", 64'(sdr_be), 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst overflow", {63'd0, overflow}, 64'd0);
    chk("rst req==ack", {63'd0, sdr_req ^ sdr_ack}, 64'd0);
    chk("rnw", {63'd0, sdr_rnw}, 64'd0);
    reset = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);

    // Two lanes of one word merge into a single full-word request
    rec.delete();
    wr(27'h100, 8'h11);
    wr(27'h101, 8'h22);
    wait_rec(1, "t1 count");
    chk_rec(0, "t1", 27'h100, 16'h2211, 2'b11);
    wait_idle("t1 idle");

    // Rewriting a filled lane overwrites it without pushing
    rec.delete();
    wr(27'h900, 8'h55);
    wr(27'h900, 8'h66);
    wr(27'h901, 8'h77);
    wait_rec(1, "ow count");
    chk_rec(0, "ow", 27'h900, 16'h7766, 2'b11);
    wait_idle("ow idle");

    // Lone high byte flushes after exactly 16 idle cycles
    rec.delete();
    wr(27'h203, 8'hAA);
    repeat (16) @(negedge clk);
    #1;
    chk("t2 not before timeout", 64'(rec.size()), 64'd0);
    @(negedge clk); #1;
    chk("t2 at timeout", 64'(rec.size()), 64'd1);
    e = (rec.size() > 0) ? rec[0] : '1;
    chk("t2 addr", 64'(e[44:18]), 64'h202);
    chk("t2 din hi", 64'(e[17:10]), 64'hAA);
    chk("t2 be", 64'(e[1:0]), 64'd2);
    wait_idle("t2 idle");

    // Address change evicts the held word; new byte waits for dl_end
    rec.delete();
    wr(27'h10, 8'h01);
    wr(27'h20, 8'h02);
    wait_rec(1, "t3 first");
    e = (rec.size() > 0) ? rec[0] : '1;
    chk("t3a addr", 64'(e[44:18]), 64'h10);
    chk("t3a din lo", 64'(e[9:2]), 64'h01);
    chk("t3a be", 64'(e[1:0]), 64'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("t3 held", 64'(rec.size()), 64'd1);
    pulse_end();
    wait_rec(2, "t3 second");
    e = (rec.size() > 1) ? rec[1] : '1;
    chk("t3b addr", 64'(e[44:18]), 64'h20);
    chk("t3b din lo", 64'(e[9:2]), 64'h02);
    chk("t3b be", 64'(e[1:0]), 64'd1);
    wait_idle("t3 idle");

    // Backpressure with ack held off, then drain of 8 words in order
    rec.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(27'h400 + 27'(2*i), 8'h10 + 8'(i));
      wr(27'h401 + 27'(2*i), 8'h80 + 8'(i));
      chk($sformatf("t4 dl_wait w%0d", i), {63'd0, dl_wait}, (i == 2) ? 64'd1 : 64'd0);
    end
    repeat (10) @(negedge clk);
    #1;
    chk("t4 one outstanding", 64'(rec.size()), 64'd1);
    chk("t4 dl_wait held", {63'd0, dl_wait}, 64'd1);
    ack_en = 1'b1;
    for (int i = 3; i < 8; i++) begin
      k = 0;
      while (dl_wait && k < 300) begin
        @(negedge clk);
        k++;
      end
      if (k >= 300) chk("t4 dl_wait stuck", {63'd0, dl_wait}, 64'd0);
      wr(27'h400 + 27'(2*i), 8'h10 + 8'(i));
      wr(27'h401 + 27'(2*i), 8'h80 + 8'(i));
    end
    wait_rec(8, "t4 count");
    for (int i = 0; i < 8; i++)
      chk_rec(i, $sformatf("t4 w%0d", i), 27'h400 + 27'(2*i),
              {8'h80 + 8'(i), 8'h10 + 8'(i)}, 2'b11);
    chk("t4 overflow", {63'd0, overflow}, 64'd0);
    wait_idle("t4 idle");

    // Reset while a request is outstanding discards everything
    ack_en = 1'b0;
    wr(27'h600, 8'h01);
    wr(27'h601, 8'h02);
    wr(27'h700, 8'h03);
    wr(27'h702, 8'h04);
    @(negedge clk);
    chk("t5 outstanding", {63'd0, sdr_req ^ sdr_ack}, 64'd1);
    chk("t5 busy before", {63'd0, busy}, 64'd1);
    do_reset();
    chk("t5 req==ack", {63'd0, sdr_req ^ sdr_ack}, 64'd0);
    @(negedge clk);
    chk("t5 busy after", {63'd0, busy}, 64'd0);
    n_tog = 0;
    repeat (40) @(negedge clk);
    chk("t5 no toggles", 64'(n_tog), 64'd0);
    chk("t5 still idle", {63'd0, busy}, 64'd0);

    // Five words with no ack: the fifth is dropped
    rec.delete();
    for (int i = 0; i < 5; i++) begin
      wr(27'h800 + 27'(2*i), 8'h30 + 8'(i));
      wr(27'h801 + 27'(2*i), 8'hC0 + 8'(i));
    end
    @(negedge clk);
    chk("t6 overflow", {63'd0, overflow}, 64'd1);
    chk("t6 dl_wait", {63'd0, dl_wait}, 64'd1);
    ack_en = 1'b1;
    wait_idle("t6 idle");
    repeat (20) @(negedge clk);
    chk("t6 issued", 64'(rec.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk_rec(i, $sformatf("t6 w%0d", i), 27'h800 + 27'(2*i),
              {8'hC0 + 8'(i), 8'h30 + 8'(i)}, 2'b11);
    chk("t6 overflow sticky", {63'd0, overflow}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
